// File: rtl/image_stream_reader_if.sv
// Bundle of control, write-port and pixel-stream signals for image_stream_reader.
// master = the reader itself, slave = the controller/sink side.
interface image_stream_reader_if #(
  parameter int PIXEL_W = 24,
  parameter int OUT_W   = 32,
  parameter int SEL_W   = 3,
  parameter int ADDR_W  = 14
);
  logic               start;
  logic               continuous;
  logic               stop;
  logic [SEL_W-1:0]   imageNumber;
  logic               hflip;
  logic               wr_en;
  logic [SEL_W-1:0]   wr_img;
  logic [ADDR_W-1:0]  wr_addr;
  logic [PIXEL_W-1:0] wr_data;
  logic [OUT_W-1:0]   fout;
  logic               out_valid;
  logic               out_ready;
  logic               sof;
  logic               eol;
  logic               eof;
  logic               busy;
  logic               sel_err;

  modport master (
    input  start, continuous, stop, imageNumber, hflip,
    input  wr_en, wr_img, wr_addr, wr_data, out_ready,
    output fout, out_valid, sof, eol, eof, busy, sel_err
  );

  modport slave (
    output start, continuous, stop, imageNumber, hflip,
    output wr_en, wr_img, wr_addr, wr_data, out_ready,
    input  fout, out_valid, sof, eol, eof, busy, sel_err
  );
endinterface

// File: rtl/image_stream_reader.sv
// Multi-image frame store streaming a selected frame over valid/ready with sof/eol/eof markers.
// Optional horizontal mirroring is enabled by defining IMAGE_READER_HFLIP_EN.
module image_stream_reader #(
  parameter int PIXEL_W    = 24,
  parameter int OUT_W      = 32,
  parameter int IMG_W      = 100,
  parameter int IMG_H      = 100,
  parameter int NUM_IMAGES = 4,
  parameter int SEL_W      = 3,
  parameter int ADDR_W     = $clog2(IMG_W*IMG_H)
) (
  input logic clk,
  input logic reset,
  image_stream_reader_if.master bus
);
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int MEM_D  = NUM_IMAGES * NPIX;
  localparam int MEM_AW = (MEM_D > 1) ? $clog2(MEM_D) : 1;
  localparam int XW     = $clog2(IMG_W + 1);
  localparam int YW     = $clog2(IMG_H + 1);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PRIME = 2'd1, S_STREAM = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;
  logic [SEL_W-1:0]   cur_img_q, cur_img_d;
  logic               flip_q, flip_d;
  logic               stop_pend_q, stop_pend_d;
  logic               sel_err_q, sel_err_d;
  logic               out_valid_q, busy_q, sof_q, eol_q, eof_q;
  logic [PIXEL_W-1:0] rd_data_q;
  logic [PIXEL_W-1:0] mem_q [MEM_D];

  logic              rd_en_s, xfer_s, at_eof_s, sel_ok_s, hflip_s, wr_ok_s;
  logic [XW-1:0]     col_s;
  logic [MEM_AW-1:0] rd_addr_s, wr_idx_s;

`ifdef IMAGE_READER_HFLIP_EN
  assign hflip_s = bus.hflip;
`else
  assign hflip_s = 1'b0;
`endif

  assign xfer_s   = out_valid_q && bus.out_ready;
  assign at_eof_s = (x_q == X_LAST) && (y_q == Y_LAST);
  assign sel_ok_s = int'(bus.imageNumber) < NUM_IMAGES;
  assign wr_ok_s  = bus.wr_en && (int'(bus.wr_img) < NUM_IMAGES) && (int'(bus.wr_addr) < NPIX);
  assign wr_idx_s = MEM_AW'(int'(bus.wr_img) * NPIX + int'(bus.wr_addr));

  // The read always targets the position that will be on the output next cycle.
  assign col_s     = flip_d ? (X_LAST - x_d) : x_d;
  assign rd_addr_s = MEM_AW'(int'(cur_img_d) * NPIX + int'(y_d) * IMG_W + int'(col_s));

  // Next-state, position and read-issue logic.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    cur_img_d   = cur_img_q;
    flip_d      = flip_q;
    stop_pend_d = stop_pend_q | bus.stop;
    sel_err_d   = sel_err_q;
    rd_en_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (sel_ok_s) begin
            state_d   = S_PRIME;
            cur_img_d = bus.imageNumber;
            flip_d    = hflip_s;
            x_d       = '0;
            y_d       = '0;
          end else begin
            sel_err_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PRIME: begin
        state_d = S_STREAM;
        rd_en_s = 1'b1;
      end
      S_STREAM: begin
        if (xfer_s) begin
          if (at_eof_s) begin
            x_d = '0;
            y_d = '0;
            if (bus.continuous && !stop_pend_q) begin
              rd_en_s = 1'b1;
              if (sel_ok_s) begin
                cur_img_d = bus.imageNumber;
                flip_d    = hflip_s;
              end else begin
                sel_err_d = 1'b1;
              end
            end else begin
              state_d     = S_IDLE;
              stop_pend_d = 1'b0;
            end
          end else begin
            rd_en_s = 1'b1;
            if (x_q == X_LAST) begin
              x_d = '0;
              y_d = y_q + YW'(1);
            end else begin
              x_d = x_q + XW'(1);
            end
          end
        end else begin
          state_d = S_STREAM;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, position, flags, output word and marker registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      cur_img_q   <= '0;
      flip_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      sel_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      eof_q       <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      cur_img_q   <= cur_img_d;
      flip_q      <= flip_d;
      stop_pend_q <= stop_pend_d;
      sel_err_q   <= sel_err_d;
      out_valid_q <= (state_d == S_STREAM);
      busy_q      <= (state_d != S_IDLE);
      sof_q       <= (state_d == S_STREAM) && (x_d == '0) && (y_d == '0);
      eol_q       <= (state_d == S_STREAM) && (x_d == X_LAST);
      eof_q       <= (state_d == S_STREAM) && (x_d == X_LAST) && (y_d == Y_LAST);
      if (rd_en_s) begin
        rd_data_q <= mem_q[rd_addr_s];
      end
    end
  end

  // Frame store write port; contents survive reset, reads see pre-write data.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_q[wr_idx_s] <= bus.wr_data;
    end
  end

  assign bus.fout      = OUT_W'(rd_data_q);
  assign bus.out_valid = out_valid_q;
  assign bus.sof       = sof_q;
  assign bus.eol       = eol_q;
  assign bus.eof       = eof_q;
  assign bus.busy      = busy_q;
  assign bus.sel_err   = sel_err_q;
endmodule
